// File: rtl/seq_subtractor.sv
// rtl/seq_subtractor.sv - multi-cycle chunked subtractor a - b - borrow_in with valid/ready handshakes
// Optional: define SUB_SATURATE_EN to clamp the result to the signed limit on overflow.
module seq_subtractor #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] difference,
    output logic             borrow_out,
    output logic             overflow
);

    localparam int N     = WIDTH / CHUNK;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

    generate
        if (WIDTH < 2 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
            $error("seq_subtractor: WIDTH must be >= 2 and a multiple of CHUNK");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             borrow_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] diff_q;
    logic             borrow_out_q;
    logic             overflow_q;
    logic             in_ready_q;
    logic             out_valid_q;

    logic [31:0]      bit_pos_d;
    logic [WIDTH-1:0] a_sh_d;
    logic [WIDTH-1:0] b_sh_d;
    logic [CHUNK:0]   chunk_d;
    logic             ovf_d;
    logic [WIDTH-1:0] sat_d;

    // The extra top bit of chunk_d is the borrow out of this chunk.
    always_comb begin
        bit_pos_d = 32'(cnt_q) * 32'(CHUNK);
        a_sh_d    = a_q >> bit_pos_d;
        b_sh_d    = b_q >> bit_pos_d;
        chunk_d   = {1'b0, a_sh_d[CHUNK-1:0]} - {1'b0, b_sh_d[CHUNK-1:0]}
                    - {{CHUNK{1'b0}}, borrow_q};
        ovf_d     = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (chunk_d[CHUNK-1] != a_q[WIDTH-1]);
        sat_d     = a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            a_q          <= '0;
            b_q          <= '0;
            borrow_q     <= 1'b0;
            cnt_q        <= '0;
            diff_q       <= '0;
            borrow_out_q <= 1'b0;
            overflow_q   <= 1'b0;
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        a_q        <= a;
                        b_q        <= b;
                        borrow_q   <= borrow_in;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= S_CALC;
                    end
                end
                S_CALC: begin
                    diff_q[bit_pos_d +: CHUNK] <= chunk_d[CHUNK-1:0];
                    borrow_q                   <= chunk_d[CHUNK];
                    cnt_q                      <= cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_CNT) begin
                        borrow_out_q <= chunk_d[CHUNK];
                        overflow_q   <= ovf_d;
                        out_valid_q  <= 1'b1;
                        state_q      <= S_DONE;
`ifdef SUB_SATURATE_EN
                        if (ovf_d) begin
                            diff_q <= sat_d;
                        end
`endif
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

`ifndef SUB_SATURATE_EN
    logic unused_sat;
    assign unused_sat = ^sat_d;
`endif

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign difference = diff_q;
    assign borrow_out = borrow_out_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_seq_subtractor.sv
// tb/tb_seq_subtractor.sv - directed self-checking bench for seq_subtractor (CHUNK=2 and CHUNK=WIDTH)
module tb_seq_subtractor;

    localparam int WIDTH = 8;
    localparam int N     = 4;
`ifdef SUB_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       borrow_in;
    logic       out_ready;
    logic [7:0] a;
    logic [7:0] b;

    logic       in_ready, out_valid, borrow_out, overflow;
    logic [7:0] difference;
    logic       in_ready1, out_valid1, borrow_out1, overflow1;
    logic [7:0] difference1;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    seq_subtractor #(.WIDTH(WIDTH), .CHUNK(2)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .borrow_in(borrow_in), .out_valid(out_valid),
        .out_ready(out_ready), .difference(difference),
        .borrow_out(borrow_out), .overflow(overflow)
    );

    seq_subtractor #(.WIDTH(WIDTH), .CHUNK(WIDTH)) u_dut_n1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
        .a(a), .b(b), .borrow_in(borrow_in), .out_valid(out_valid1),
        .out_ready(out_ready), .difference(difference1),
        .borrow_out(borrow_out1), .overflow(overflow1)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic start_op(input logic [7:0] av, input logic [7:0] bv, input logic bi);
        int waited = 0;
        @(negedge clk);
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check_val("accept_ready", 32'(in_ready), 32'd1);
        a         = av;
        b         = bv;
        borrow_in = bi;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        a         = ~av;
        b         = ~bv;
        borrow_in = ~bi;
    endtask

    task automatic wait_done(input string tag, input logic [7:0] ed, input logic ebo, input logic eov);
        int cyc = 0;
        @(negedge clk);
        while (!out_valid && cyc < 50) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (cyc == 1)
                check_val({tag, "_n1"}, 32'({overflow1, borrow_out1, out_valid1, difference1}),
                          32'({eov, ebo, 1'b1, ed}));
        end
        check_val({tag, "_lat"}, 32'(cyc), 32'(N));
        check_val({tag, "_res"}, 32'({overflow, borrow_out, difference}), 32'({eov, ebo, ed}));
    endtask

    task automatic check_idle(input string tag);
        check_val(tag, 32'({in_ready, out_valid}), 32'b10);
    endtask

    typedef struct {
        logic [7:0] av;
        logic [7:0] bv;
        logic       bi;
        logic [7:0] d;
        logic       bo;
        logic       ov;
    } vec_t;

    vec_t vecs[$];

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = 8'h00;
        b         = 8'h00;
        borrow_in = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("reset", 32'({in_ready, out_valid, borrow_out, overflow, difference}),
                  32'({1'b1, 1'b0, 1'b0, 1'b0, 8'h00}));
        rst = 1'b0;

        vecs.push_back('{8'h06, 8'h03, 1'b0, 8'h03, 1'b0, 1'b0});
        vecs.push_back('{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0});
        vecs.push_back('{8'h05, 8'h05, 1'b1, 8'hFF, 1'b1, 1'b0});
        vecs.push_back('{8'h80, 8'h01, 1'b0, SAT ? 8'h80 : 8'h7F, 1'b0, 1'b1});
        vecs.push_back('{8'h7F, 8'hFF, 1'b0, SAT ? 8'h7F : 8'h80, 1'b1, 1'b1});
        vecs.push_back('{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0});

        foreach (vecs[i]) begin
            start_op(vecs[i].av, vecs[i].bv, vecs[i].bi);
            wait_done($sformatf("vec%0d", i), vecs[i].d, vecs[i].bo, vecs[i].ov);
            @(negedge clk);
            check_idle($sformatf("vec%0d_xfer", i));
        end

        // Hold the result in DONE while new operands are offered.
        out_ready = 1'b0;
        start_op(8'h09, 8'h04, 1'b0);
        wait_done("bp", 8'h05, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            in_valid = (i % 2 == 0);
            a        = 8'h33;
            b        = 8'h11;
            @(negedge clk);
            check_val($sformatf("bp_hold%0d", i),
                      32'({in_ready, out_valid, overflow, borrow_out, difference}),
                      32'({1'b0, 1'b1, 1'b0, 1'b0, 8'h05}));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check_idle("bp_xfer");
        @(negedge clk);
        check_idle("bp_no_capture");

        // Abort in the second CALC cycle.
        start_op(8'h06, 8'h03, 1'b0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_val("mid_reset", 32'({in_ready, out_valid, borrow_out, overflow, difference}),
                  32'({1'b1, 1'b0, 1'b0, 1'b0, 8'h00}));
        start_op(8'h06, 8'h03, 1'b0);
        wait_done("after_rst", 8'h03, 1'b0, 1'b0);
        @(negedge clk);
        check_idle("after_rst_xfer");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
